// File: rtl/scan_ctrl_139.sv
// scan_ctrl_139: scan driver for a dual 2-to-4 decoder.
//
// The block steps the decoder select {B,A} through slots 0..3. Each slot is
// enabled (G_L low) for DWELL cycles. Between slots, G_L is forced high for
// BLANK_CYC cycles, and the select advances in the middle of that blanking
// window. The decoder therefore never sees a select change while it is
// enabled.
//
// Ports:
//   CLK        system clock, rising edge
//   RST_L      asynchronous active-low reset
//   RUN        scan enable, level-sensitive; it is sampled in IDLE and in
//              the last BLANK cycle
//   DIR        (only when SCAN_DIR_EN is defined) 0 = increment, 1 = decrement
//   A, B       decoder select bits 0 and 1
//   G_L        active-low decoder enable
//   SLOT_DONE  one-cycle pulse after the slot shown on {B,A} completes
//   BUSY       high whenever the controller is not idle
//
// Optional feature: define SCAN_DIR_EN to add the DIR input.
// The DIR input is sampled on the edge where the select advances.
//
// Parameter limits: DWELL must be in 1..2^DWELL_W-1, and BLANK_CYC must be >= 2.
// The select advances on the edge that ends the first blanking cycle. At
// least two blanking cycles are needed so that G_L is high on both sides of
// that edge.
// All outputs come straight from flops.

module scan_ctrl_139 #(
  parameter int unsigned DWELL_W   = 16,
  parameter int unsigned DWELL     = 1000,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic CLK,
  input  logic RST_L,
  input  logic RUN,
`ifdef SCAN_DIR_EN
  input  logic DIR,
`endif
  output logic A,
  output logic B,
  output logic G_L,
  output logic SLOT_DONE,
  output logic BUSY
);

  localparam int unsigned BlankW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StBlank, StActive} state_e;

  state_e               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [BlankW-1:0]    blank_cnt_q, blank_cnt_d;
  logic                 adv_q, adv_d;
  logic                 g_l_q, g_l_d;
  logic                 slot_done_q, slot_done_d;
  logic                 busy_q, busy_d;
  logic [1:0]           step;

  localparam logic [DWELL_W-1:0] DwellLast = DWELL_W'(DWELL - 1);
  localparam logic [BlankW-1:0]  BlankLast = BlankW'(BLANK_CYC - 1);

  // Adding 3 modulo 4 is the same as decrementing, so one adder serves both directions.
  always_comb begin
`ifdef SCAN_DIR_EN
    step = DIR ? 2'd3 : 2'd1;
`else
    step = 2'd1;
`endif
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    dwell_cnt_d = dwell_cnt_q;
    blank_cnt_d = blank_cnt_q;
    adv_d       = adv_q;
    g_l_d       = g_l_q;
    slot_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        g_l_d = 1'b1;
        if (RUN) begin
          // A start from idle shows the current address; it does not advance first.
          state_d     = StBlank;
          blank_cnt_d = '0;
          adv_d       = 1'b0;
        end
      end

      StBlank: begin
        g_l_d       = 1'b1;
        blank_cnt_d = blank_cnt_q + 1'b1;
        if (blank_cnt_q == '0 && adv_q) begin
          // This edge ends the first blanking cycle. G_L is high on both sides of it.
          sel_d = sel_q + step;
          adv_d = 1'b0;
        end
        if (blank_cnt_q == BlankLast) begin
          blank_cnt_d = '0;
          if (RUN) begin
            state_d     = StActive;
            g_l_d       = 1'b0;
            dwell_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StActive: begin
        // RUN is ignored here; a slot that has started always runs its full dwell.
        g_l_d       = 1'b0;
        dwell_cnt_d = dwell_cnt_q + 1'b1;
        if (dwell_cnt_q == DwellLast) begin
          state_d     = StBlank;
          g_l_d       = 1'b1;
          blank_cnt_d = '0;
          adv_d       = 1'b1;
          slot_done_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        g_l_d   = 1'b1;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q     <= StIdle;
      sel_q       <= 2'd0;
      dwell_cnt_q <= '0;
      blank_cnt_q <= '0;
      adv_q       <= 1'b0;
      g_l_q       <= 1'b1;
      slot_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      dwell_cnt_q <= dwell_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      adv_q       <= adv_d;
      g_l_q       <= g_l_d;
      slot_done_q <= slot_done_d;
      busy_q      <= busy_d;
    end
  end

  assign A         = sel_q[0];
  assign B         = sel_q[1];
  assign G_L       = g_l_q;
  assign SLOT_DONE = slot_done_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_scan_ctrl_139.sv
// Testbench for scan_ctrl_139.
// dut0 runs with DWELL=4 and BLANK_CYC=2.
// dut1 runs with DWELL=1 and BLANK_CYC=3 and is used for the select-glitch check.
// Stimulus pushes the expected slot addresses into queues. Separate monitors
// pop those entries when a G_L-low window starts and on each SLOT_DONE pulse.

module tb_scan_ctrl_139;

  localparam int unsigned DWELL = 4;

  logic clk   = 1'b0;
  logic rst_l = 1'b1;
  logic run   = 1'b0;
  logic a0, b0, gl0, sd0, busy0;
  logic a1, b1, gl1, sd1, busy1;
`ifdef SCAN_DIR_EN
  logic dir = 1'b0;
`endif

  always #5 clk = ~clk;

  scan_ctrl_139 #(.DWELL_W(8), .DWELL(4), .BLANK_CYC(2)) dut0 (
    .CLK(clk), .RST_L(rst_l), .RUN(run),
`ifdef SCAN_DIR_EN
    .DIR(dir),
`endif
    .A(a0), .B(b0), .G_L(gl0), .SLOT_DONE(sd0), .BUSY(busy0)
  );

  scan_ctrl_139 #(.DWELL_W(4), .DWELL(1), .BLANK_CYC(3)) dut1 (
    .CLK(clk), .RST_L(rst_l), .RUN(run),
`ifdef SCAN_DIR_EN
    .DIR(dir),
`endif
    .A(a1), .B(b1), .G_L(gl1), .SLOT_DONE(sd1), .BUSY(busy1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the current address, the scan direction, and the expected event queues.
  int exp_win[$];
  int exp_done[$];
  int cur   = 0;
  bit dir_m = 1'b0;

  function automatic int nxt(input int s);
    return dir_m ? ((s + 3) % 4) : ((s + 1) % 4);
  endfunction

  // Monitor for dut0.
  int ab0, prev_ab0, win_len0, win_addr0;
  bit prev_gl0 = 1'b1;
  bit in_win0  = 1'b0;
  bit moved0   = 1'b0;
  always @(negedge clk) begin
    ab0 = int'({b0, a0});
    if (!rst_l) begin
      in_win0  = 1'b0;
      prev_gl0 = 1'b1;
      prev_ab0 = ab0;
    end else begin
      if (ab0 != prev_ab0) check("ab_change_blanked0", int'(prev_gl0 && gl0), 1);
      if (!gl0 && prev_gl0) begin
        in_win0   = 1'b1;
        win_len0  = 1;
        win_addr0 = ab0;
        moved0    = 1'b0;
        if (exp_win.size() == 0) check("window_expected", 0, 1);
        else check("window_addr", ab0, exp_win.pop_front());
      end else if (!gl0 && in_win0) begin
        win_len0++;
        if (ab0 != win_addr0) moved0 = 1'b1;
      end else if (gl0 && in_win0) begin
        in_win0 = 1'b0;
        check("window_len", win_len0, DWELL);
        check("window_addr_stable", int'(moved0), 0);
      end
      if (sd0) begin
        check("done_first_blank", int'(gl0 && !prev_gl0), 1);
        if (exp_done.size() == 0) check("done_expected", 0, 1);
        else check("done_addr", ab0, exp_done.pop_front());
      end
      prev_gl0 = gl0;
      prev_ab0 = ab0;
    end
  end

  // Monitor for dut1: the select may change only while G_L is high both before and after the edge.
  int ab1, prev_ab1, win_len1;
  bit prev_gl1 = 1'b1;
  bit in_win1  = 1'b0;
  always @(negedge clk) begin
    ab1 = int'({b1, a1});
    if (!rst_l) begin
      in_win1  = 1'b0;
      prev_gl1 = 1'b1;
      prev_ab1 = ab1;
    end else begin
      if (ab1 != prev_ab1) check("ab_change_blanked1", int'(prev_gl1 && gl1), 1);
      if (!gl1 && !in_win1) begin
        in_win1  = 1'b1;
        win_len1 = 1;
      end else if (!gl1) begin
        win_len1++;
      end else if (in_win1) begin
        in_win1 = 1'b0;
        check("window_len1", win_len1, 1);
      end
      prev_gl1 = gl1;
      prev_ab1 = ab1;
    end
  end

  task automatic run_phase(input int n, input bit do_reset);
    int  seen, cyc, lat, w;
    bit  prevg, toggle_pending;
    for (int k = 0; k < n; k++) begin
      exp_win.push_back(cur);
      exp_done.push_back(cur);
      cur = nxt(cur);
    end
    run            = 1'b1;
    seen           = 0;
    cyc            = 0;
    prevg          = gl0;
    toggle_pending = 1'b0;
    while (seen < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (toggle_pending) begin
        run            = 1'b1;
        toggle_pending = 1'b0;
      end else if (sd0 && $urandom_range(0, 1) == 1) begin
        // A dip during the first blanking cycle must have no effect.
        run            = 1'b0;
        toggle_pending = 1'b1;
      end
      if (!gl0 && prevg) seen++;
      prevg = gl0;
    end
    if (seen < n) check("phase_windows", seen, n);

    if (do_reset) begin
      @(negedge clk);
      #2 rst_l = 1'b0;
      #1;
      check("midrst_gl", int'(gl0), 1);
      check("midrst_ab", int'({b0, a0}), 0);
      check("midrst_done", int'(sd0), 0);
      check("midrst_busy", int'(busy0), 0);
      exp_win.delete();
      exp_done.delete();
      exp_win.push_back(0);
      exp_done.push_back(0);
      cur = nxt(0);
      @(negedge clk);
      #2 rst_l = 1'b1;
      lat = 0;
      while (lat < 10) begin
        @(negedge clk);
        lat++;
        if (!gl0) break;
      end
      check("restart_latency", lat, 3);
    end

    repeat ($urandom_range(0, DWELL - 1)) @(negedge clk);
    run = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (busy0 && w < 50);
    check("busy_clears", int'(busy0), 0);
    check("idle_addr", int'({b0, a0}), cur);
    check("idle_gl", int'(gl0), 1);
    check("idle_done", int'(sd0), 0);
  endtask

  initial begin
    #2 rst_l = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gl", int'(gl0), 1);
    check("rst_a", int'(a0), 0);
    check("rst_b", int'(b0), 0);
    check("rst_done", int'(sd0), 0);
    check("rst_busy", int'(busy0), 0);
    #2 rst_l = 1'b1;
    cur = 0;
`ifdef SCAN_DIR_EN
    dir   = 1'b1;
    dir_m = 1'b1;
`endif
    repeat (2) @(negedge clk);
    run_phase(5, 1'b0);
    for (int p = 0; p < 6; p++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
`ifdef SCAN_DIR_EN
      dir   = 1'($urandom_range(0, 1));
      dir_m = dir;
`endif
      if (p == 2) run_phase(3, 1'b1);
      else run_phase(int'($urandom_range(1, 6)), 1'b0);
    end
    repeat (5) @(negedge clk);
    check("win_queue_empty", exp_win.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
